multi_cycle_controller: RTL and testbench

MULTI_CYCLE_CONTROLLER -- requirements
Module: multi_cycle_controller

---
 rtl/multi_cycle_controller_if.sv | 32 +++
 rtl/multi_cycle_controller.sv | 165 ++++++++++++++++
 tb/tb_multi_cycle_controller.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_controller_if.sv
// Control/status bundle between the multi-cycle controller and its datapath/memory.
// master = controller side, slave = datapath side.
interface multi_cycle_controller_if;
    logic [5:0] Operator;
    logic [5:0] Func;
    logic       ALUZero;
    logic       MemReady;
    logic       MemReq;
    logic       MemWe;
    logic       IorD;
    logic       IRWrite;
    logic       PCWrite;
    logic [1:0] PCSource;
    logic       RegWrite;
    logic       Link;
    logic [2:0] State;
    logic       InstrDone;
    logic       Illegal;
    logic       Fault;

    modport master (
        input  Operator, Func, ALUZero, MemReady,
        output MemReq, MemWe, IorD, IRWrite, PCWrite, PCSource,
               RegWrite, Link, State, InstrDone, Illegal, Fault
    );

    modport slave (
        output Operator, Func, ALUZero, MemReady,
        input  MemReq, MemWe, IorD, IRWrite, PCWrite, PCSource,
               RegWrite, Link, State, InstrDone, Illegal, Fault
    );
endinterface

// File: rtl/multi_cycle_controller.sv
// Multi-cycle MIPS-subset control FSM with memory wait timeout.
// Strobes are decoded from the registered state and current inputs; Reset forces every output low.
module multi_cycle_controller #(
    parameter int unsigned TIMEOUT = 15
) (
    input logic                       Clock,
    input logic                       Reset,
    multi_cycle_controller_if.master  bus
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEMACC = 3'd3,
        WBACK  = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J    = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04, OP_BNE  = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09, OP_ANDI = 6'h0C, OP_ORI  = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E, OP_LUI  = 6'h0F, OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_SRA = 6'h03, FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       timeout;

    logic is_alu, is_lw, is_sw, is_beq, is_bne, is_j, is_jal, is_jr;
    logic mem_req, mem_we, iord, ir_write, pc_write, reg_write, link;
    logic instr_done, illegal, fault;
    logic [1:0] pc_source;

    always_comb begin
        is_alu = 1'b0; is_lw = 1'b0; is_sw = 1'b0; is_beq = 1'b0;
        is_bne = 1'b0; is_j  = 1'b0; is_jal = 1'b0; is_jr = 1'b0;
        case (bus.Operator)
            OP_RTYPE: begin
                case (bus.Func)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_XOR,
                    FN_SLL, FN_SRL, FN_SRA: is_alu = 1'b1;
                    FN_JR:                  is_jr  = 1'b1;
                    default: ;
                endcase
            end
            OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: is_alu = 1'b1;
            OP_LW:  is_lw  = 1'b1;
            OP_SW:  is_sw  = 1'b1;
            OP_BEQ: is_beq = 1'b1;
            OP_BNE: is_bne = 1'b1;
            OP_J:   is_j   = 1'b1;
            OP_JAL: is_jal = 1'b1;
            default: ;
        endcase
    end

    assign timeout = (wait_q == 4'(TIMEOUT - 1));

    // wait_d defaults to zero, so every transition (including a timeout back
    // into FETCH) enters FETCH/MEMACC with a cleared counter.
    always_comb begin
        state_d    = FETCH;
        wait_d     = '0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_source  = 2'b00;
        reg_write  = 1'b0;
        link       = 1'b0;
        instr_done = 1'b0;
        illegal    = 1'b0;
        fault      = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req = 1'b1;
                if (bus.MemReady) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end else if (timeout) begin
                    fault = 1'b1;
                end else begin
                    wait_d  = wait_q + 4'd1;
                    state_d = FETCH;
                end
            end
            DECODE: begin
                if (is_j || is_jal) begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    reg_write  = is_jal;
                    link       = is_jal;
                    instr_done = 1'b1;
                end else if (is_jr) begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b11;
                    instr_done = 1'b1;
                end else if (is_alu || is_lw || is_sw || is_beq || is_bne) begin
                    state_d = EXEC;
                end else begin
                    illegal = 1'b1;
                end
            end
            EXEC: begin
                if (is_beq || is_bne) begin
                    pc_write   = is_beq ? bus.ALUZero : ~bus.ALUZero;
                    pc_source  = 2'b01;
                    instr_done = 1'b1;
                end else if (is_lw || is_sw) begin
                    state_d = MEMACC;
                end else if (is_alu) begin
                    state_d = WBACK;
                end
            end
            MEMACC: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = is_sw;
                if (bus.MemReady) begin
                    instr_done = is_sw;
                    state_d    = is_sw ? FETCH : WBACK;
                end else if (timeout) begin
                    fault = 1'b1;
                end else begin
                    wait_d  = wait_q + 4'd1;
                    state_d = MEMACC;
                end
            end
            WBACK: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    assign bus.MemReq    = mem_req    & ~Reset;
    assign bus.MemWe     = mem_we     & ~Reset;
    assign bus.IorD      = iord       & ~Reset;
    assign bus.IRWrite   = ir_write   & ~Reset;
    assign bus.PCWrite   = pc_write   & ~Reset;
    assign bus.PCSource  = Reset ? 2'b00 : pc_source;
    assign bus.RegWrite  = reg_write  & ~Reset;
    assign bus.Link      = link       & ~Reset;
    assign bus.State     = Reset ? 3'b000 : state_q;
    assign bus.InstrDone = instr_done & ~Reset;
    assign bus.Illegal   = illegal    & ~Reset;
    assign bus.Fault     = fault      & ~Reset;

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench: a per-instruction reference model pushes the expected
// output vector for every cycle; a negedge monitor pops and compares.
module tb_multi_cycle_controller;

  localparam int unsigned TO = 4;

  typedef struct packed {
    logic [2:0] state;
    logic       mem_req;
    logic       mem_we;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic [1:0] pc_source;
    logic       reg_write;
    logic       link;
    logic       done;
    logic       illegal;
    logic       fault;
  } out_t;

  typedef struct {
    out_t  v;
    string tag;
  } exp_t;

  typedef enum { C_ILL, C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_JR } cls_e;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  exp_t  exp_q[$];
  int    total = 0;
  int    bad = 0;
  bit    stim_done = 1'b0;
  string cur_tag = "reset";

  logic [5:0] r_fns [9]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03, 6'h08};
  logic [5:0] i_ops [12] = '{6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                             6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03};

  multi_cycle_controller_if bus();

  multi_cycle_controller #(.TIMEOUT(TO)) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  function automatic out_t idle(input int st);
    out_t o;
    o = '0;
    o.state = 3'(st);
    return o;
  endfunction

  function automatic cls_e classify(input logic [5:0] op, input logic [5:0] fn);
    cls_e c;
    c = C_ILL;
    case (op)
      6'h00: begin
        if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h00, 6'h02, 6'h03}) c = C_ALU;
        else if (fn == 6'h08) c = C_JR;
      end
      6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F: c = C_ALU;
      6'h23: c = C_LW;
      6'h2B: c = C_SW;
      6'h04: c = C_BEQ;
      6'h05: c = C_BNE;
      6'h02: c = C_J;
      6'h03: c = C_JAL;
      default: c = C_ILL;
    endcase
    return c;
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic mr,
                       input logic az, input logic r, input out_t e);
    exp_t x;
    bus.Operator = op;
    bus.Func     = fn;
    bus.MemReady = mr;
    bus.ALUZero  = az;
    rst          = r;
    x.v   = e;
    x.tag = cur_tag;
    exp_q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // fd/md: cycles of MemReady=0 before MemReady=1 in FETCH / MEMACC.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int unsigned fd, input int unsigned md, input logic az);
    out_t e;
    cls_e c;
    c = classify(op, fn);
    for (int unsigned k = 0; k < TO; k++) begin
      e = idle(0);
      e.mem_req = 1'b1;
      if (k == fd) begin
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        drive(r6(), r6(), 1'b1, rb(), 1'b0, e);
        break;
      end
      if (k == TO - 1) begin
        e.fault = 1'b1;
        drive(r6(), r6(), 1'b0, rb(), 1'b0, e);
        return;
      end
      drive(r6(), r6(), 1'b0, rb(), 1'b0, e);
    end

    e = idle(1);
    case (c)
      C_ILL: e.illegal = 1'b1;
      C_J:   begin e.pc_write = 1'b1; e.pc_source = 2'd2; e.done = 1'b1; end
      C_JAL: begin
        e.pc_write = 1'b1; e.pc_source = 2'd2; e.done = 1'b1;
        e.reg_write = 1'b1; e.link = 1'b1;
      end
      C_JR:  begin e.pc_write = 1'b1; e.pc_source = 2'd3; e.done = 1'b1; end
      default: ;
    endcase
    drive(op, fn, rb(), rb(), 1'b0, e);
    if (c inside {C_ILL, C_J, C_JAL, C_JR}) return;

    e = idle(2);
    if (c == C_BEQ || c == C_BNE) begin
      e.pc_write  = (c == C_BEQ) ? az : ~az;
      e.pc_source = 2'd1;
      e.done      = 1'b1;
    end
    drive(op, fn, rb(), az, 1'b0, e);
    if (c == C_BEQ || c == C_BNE) return;

    if (c == C_LW || c == C_SW) begin
      for (int unsigned k = 0; k < TO; k++) begin
        e = idle(3);
        e.mem_req = 1'b1;
        e.iord    = 1'b1;
        e.mem_we  = (c == C_SW);
        if (k == md) begin
          e.done = (c == C_SW);
          drive(op, fn, 1'b1, rb(), 1'b0, e);
          if (c == C_SW) return;
          break;
        end
        if (k == TO - 1) begin
          e.fault = 1'b1;
          drive(op, fn, 1'b0, rb(), 1'b0, e);
          return;
        end
        drive(op, fn, 1'b0, rb(), 1'b0, e);
      end
    end

    e = idle(4);
    e.reg_write = 1'b1;
    e.done      = 1'b1;
    drive(op, fn, rb(), rb(), 1'b0, e);
  endtask

  task automatic sw_reset();
    out_t e;
    logic [5:0] fn;
    fn = r6();
    e = idle(0); e.mem_req = 1'b1; e.ir_write = 1'b1; e.pc_write = 1'b1;
    drive(r6(), r6(), 1'b1, rb(), 1'b0, e);
    drive(6'h2B, fn, rb(), rb(), 1'b0, idle(1));
    drive(6'h2B, fn, rb(), rb(), 1'b0, idle(2));
    e = idle(3); e.mem_req = 1'b1; e.iord = 1'b1; e.mem_we = 1'b1;
    drive(6'h2B, fn, 1'b0, rb(), 1'b0, e);
    drive(6'h2B, fn, 1'b1, rb(), 1'b1, '0);
  endtask

  initial begin : stimulus
    logic [5:0] op, fn;
    int unsigned fd, md;
    bus.Operator = '0;
    bus.Func     = '0;
    bus.MemReady = 1'b0;
    bus.ALUZero  = 1'b0;
    rst          = 1'b1;
    @(posedge clk);
    #1;
    drive(r6(), r6(), rb(), rb(), 1'b1, '0);
    drive(r6(), r6(), rb(), rb(), 1'b1, '0);

    cur_tag = "add";              run_instr(6'h00, 6'h20, 0, 0, 1'b0);
    cur_tag = "lw_wait3";         run_instr(6'h23, r6(), 0, 3, 1'b0);
    cur_tag = "beq_az0";          run_instr(6'h04, r6(), 0, 0, 1'b0);
    cur_tag = "bne_az0";          run_instr(6'h05, r6(), 0, 0, 1'b0);
    cur_tag = "beq_az1";          run_instr(6'h04, r6(), 1, 0, 1'b1);
    cur_tag = "illegal";          run_instr(6'h00, 6'h3F, 0, 0, 1'b0);
    cur_tag = "jal";              run_instr(6'h03, r6(), 0, 0, 1'b0);
    cur_tag = "jr";               run_instr(6'h00, 6'h08, 0, 0, 1'b0);
    cur_tag = "fetch_timeout";    run_instr(6'h00, 6'h20, 4, 0, 1'b0);
    cur_tag = "fetch_ready_last"; run_instr(6'h00, 6'h20, 3, 0, 1'b0);
    cur_tag = "mem_timeout";      run_instr(6'h2B, r6(), 0, 9, 1'b0);
    cur_tag = "sw_ready_last";    run_instr(6'h2B, r6(), 2, 3, 1'b0);
    cur_tag = "sw_reset";         sw_reset();
    cur_tag = "after_reset";      run_instr(6'h02, r6(), 3, 0, 1'b0);

    cur_tag = "random";
    for (int unsigned i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin op = 6'h00; fn = r_fns[$urandom_range(0, 8)]; end
        4, 5, 6, 7, 8: begin op = i_ops[$urandom_range(0, 11)]; fn = r6(); end
        default: begin op = r6(); fn = r6(); end
      endcase
      fd = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
      md = ($urandom_range(0, 7) == 0) ? $urandom_range(3, 6) : $urandom_range(0, 2);
      run_instr(op, fn, fd, md, rb());
    end
    stim_done = 1'b1;
  end

  initial begin : monitor
    exp_t x;
    out_t act;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        act.state     = bus.State;
        act.mem_req   = bus.MemReq;
        act.mem_we    = bus.MemWe;
        act.iord      = bus.IorD;
        act.ir_write  = bus.IRWrite;
        act.pc_write  = bus.PCWrite;
        act.pc_source = bus.PCSource;
        act.reg_write = bus.RegWrite;
        act.link      = bus.Link;
        act.done      = bus.InstrDone;
        act.illegal   = bus.Illegal;
        act.fault     = bus.Fault;
        total++;
        if (act !== x.v) begin
          bad++;
          $display("FAIL %s t=%0t: actual=%b required=%b (state,req,we,iord,irw,pcw,pcsrc,regw,link,done,ill,fault)",
                   x.tag, $time, act, x.v);
        end
      end else if (stim_done) begin
        break;
      end
    end
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d expected vectors never compared", exp_q.size());
    end
    if (total == 0) begin
      bad++;
      $display("FAIL scoreboard: no comparisons were made");
    end
    if (bad != 0) $display("FAIL summary: %0d mismatches", bad);
    else $display("PASS summary: all %0d cycles matched", total);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
